check_scoreboard: RTL and testbench

- Downstream consumer of the ALU result checker (`check`).
- Records each checkable instruction when it issues (pcEn high), matches it against the checker's OpDone pulses in order, and flags any instruction with no OpDone within TIMEOUT cycles as failed.
- Keeps saturating pass/fail/skip/spurious counters, a sticky error flag and the first failing instruction word, for the Veloce testbench to read at end of run.

---
 rtl/AluCtrlSig_pkg.sv | 34 +++
 rtl/check_scoreboard_fifo.sv | 60 ++++++
 rtl/check_scoreboard.sv | 147 ++++++++++++++
 tb/tb_check_scoreboard.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/AluCtrlSig_pkg.sv
// -----------------------------------------------------------------------------
// AluCtrlSig_pkg
//   Shared opcode constants for the ALU control path and the types used by
//   the result scoreboard that sits behind the `check` block.
//
//   Contents:
//     *_op          6-bit opcode constants (inst[31:26])
//     sb_entry_t    one pending scoreboard entry: issued word + issue timestamp
//     is_checkable  1 when the opcode produces an OpDone pulse from `check`
// -----------------------------------------------------------------------------
package AluCtrlSig_pkg;

    localparam logic [5:0] ADD_op  = 6'b000000;
    localparam logic [5:0] J_op    = 6'b000010;
    localparam logic [5:0] BEQ_op  = 6'b000100;
    localparam logic [5:0] BNE_op  = 6'b000101;
    localparam logic [5:0] ADDI_op = 6'b001000;
    localparam logic [5:0] ANDI_op = 6'b001100;
    localparam logic [5:0] ORI_op  = 6'b001101;
    localparam logic [5:0] LW_op   = 6'b100011;
    localparam logic [5:0] SW_op   = 6'b101011;

    typedef struct packed {
        logic [31:0] inst;
        logic [7:0]  ts;
    } sb_entry_t;

    // Only ADD and ADDI are verified by `check`; every other opcode is
    // counted as skipped and never expects an OpDone.
    function automatic logic is_checkable(input logic [5:0] opcode);
        return (opcode == ADD_op) || (opcode == ADDI_op);
    endfunction

endpackage

// File: rtl/check_scoreboard_fifo.sv
// -----------------------------------------------------------------------------
// sb_fifo
//   In-order store of pending scoreboard entries. Pointers carry one extra
//   wrap bit so full and empty are distinguishable and count = wptr - rptr.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset (pointers only)
//     push         write push_data at the tail (caller guarantees room,
//                  which includes the case full && pop)
//     push_data    entry to store
//     pop          drop the head entry (caller guarantees non-empty)
//     head         current head entry (undefined when empty)
//     full, empty  occupancy flags
//     count        occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sb_fifo
    import AluCtrlSig_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  sb_entry_t               push_data,
    input  logic                    pop,
    output sb_entry_t               head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);

    sb_entry_t     mem [DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    // With push && pop while full, the write lands in the slot the head
    // vacates, which is exactly where wptr points.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rptr[AW-1:0]];
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign count = wptr - rptr;

endmodule

// File: rtl/check_scoreboard.sv
// -----------------------------------------------------------------------------
// check_scoreboard
//   Tracks every checkable instruction issued to the ALU result checker and
//   matches the checker's OpDone pulses against them in issue order. An entry
//   with no OpDone within TIMEOUT cycles is retired as failed.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     pcEn, inst        issue strobe and instruction word
//     OpDone            pass pulse from `check`
//     issue_cnt         checkable issues accepted into the FIFO
//     skip_cnt          non-checkable issues
//     pass_cnt          entries retired by OpDone
//     fail_cnt          entries retired by timeout
//     ovf_cnt           checkable issues dropped on a full FIFO
//     spurious_cnt      OpDone pulses with nothing pending
//     pending, idle     FIFO occupancy, pending == 0
//     err               sticky: any fail, overflow or spurious event
//     first_fail_valid  sticky: first_fail_inst is meaningful
//     first_fail_inst   word of the first entry that timed out
//
//   Interface: pcEn and OpDone are single-cycle strobes sampled on every
//   rising edge; there is no backpressure, so the scoreboard must accept or
//   account for every strobe in the cycle it arrives.
// -----------------------------------------------------------------------------
module check_scoreboard
    import AluCtrlSig_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 6,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        pcEn,
    input  logic [31:0]                 inst,
    input  logic                        OpDone,
    output logic [CNT_W-1:0]            issue_cnt,
    output logic [CNT_W-1:0]            skip_cnt,
    output logic [CNT_W-1:0]            pass_cnt,
    output logic [CNT_W-1:0]            fail_cnt,
    output logic [CNT_W-1:0]            ovf_cnt,
    output logic [CNT_W-1:0]            spurious_cnt,
    output logic [$clog2(DEPTH+1)-1:0]  pending,
    output logic                        idle,
    output logic                        err,
    output logic                        first_fail_valid,
    output logic [31:0]                 first_fail_inst
);

    localparam int         PW         = $clog2(DEPTH+1);
    localparam int         CW         = $clog2(DEPTH) + 1;
    localparam logic [7:0] TIMEOUT_TS = 8'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             en);
        if (en && (v != {CNT_W{1'b1}})) return v + 1'b1;
        return v;
    endfunction

    // Free-running issue timestamp; ages are taken modulo 256, which is
    // unambiguous because TIMEOUT never exceeds 255.
    logic [7:0]    ts;

    sb_entry_t     head;
    sb_entry_t     push_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] next_count;
    logic [7:0]    head_age;

    logic checkable;
    logic do_pass;
    logic do_fail;
    logic do_spur;
    logic do_pop;
    logic do_skip;
    logic do_ovf;
    logic do_push;

    // Retire looks only at the entry already at the head, so an OpDone in
    // the cycle of a push can never match the entry being pushed.
    always_comb begin
        head_age   = ts - head.ts;
        do_pass    = OpDone && !fifo_empty;
        do_fail    = !OpDone && !fifo_empty && (head_age >= TIMEOUT_TS);
        do_spur    = OpDone && fifo_empty;
        do_pop     = do_pass || do_fail;

        checkable  = pcEn && is_checkable(inst[31:26]);
        do_skip    = pcEn && !checkable;
        // A pop in the same cycle frees the slot the push needs.
        do_ovf     = checkable && fifo_full && !do_pop;
        do_push    = checkable && !do_ovf;

        push_data  = '{inst: inst, ts: ts};
        next_count = fifo_count + CW'(do_push) - CW'(do_pop);
    end

    sb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (do_push),
        .push_data (push_data),
        .pop       (do_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts               <= '0;
            issue_cnt        <= '0;
            skip_cnt         <= '0;
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            ovf_cnt          <= '0;
            spurious_cnt     <= '0;
            pending          <= '0;
            idle             <= 1'b1;
            err              <= 1'b0;
            first_fail_valid <= 1'b0;
            first_fail_inst  <= '0;
        end else begin
            ts           <= ts + 8'd1;
            issue_cnt    <= sat_inc(issue_cnt,    do_push);
            skip_cnt     <= sat_inc(skip_cnt,     do_skip);
            pass_cnt     <= sat_inc(pass_cnt,     do_pass);
            fail_cnt     <= sat_inc(fail_cnt,     do_fail);
            ovf_cnt      <= sat_inc(ovf_cnt,      do_ovf);
            spurious_cnt <= sat_inc(spurious_cnt, do_spur);
            pending      <= PW'(next_count);
            idle         <= (next_count == '0);
            if (do_fail || do_ovf || do_spur) err <= 1'b1;
            if (do_fail && !first_fail_valid) begin
                first_fail_valid <= 1'b1;
                first_fail_inst  <= head.inst;
            end
        end
    end

endmodule

// File: tb/tb_check_scoreboard.sv
module tb_check_scoreboard;
    import AluCtrlSig_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 6;
    localparam int CNT_W   = 16;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pcEn = 1'b0;
    logic [31:0] inst = '0;
    logic        OpDone = 1'b0;

    logic [CNT_W-1:0] issue_cnt, skip_cnt, pass_cnt, fail_cnt, ovf_cnt, spurious_cnt;
    logic [2:0]       pending;
    logic             idle, err, first_fail_valid;
    logic [31:0]      first_fail_inst;

    always #5 clk = ~clk;

    check_scoreboard #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pcEn             (pcEn),
        .inst             (inst),
        .OpDone           (OpDone),
        .issue_cnt        (issue_cnt),
        .skip_cnt         (skip_cnt),
        .pass_cnt         (pass_cnt),
        .fail_cnt         (fail_cnt),
        .ovf_cnt          (ovf_cnt),
        .spurious_cnt     (spurious_cnt),
        .pending          (pending),
        .idle             (idle),
        .err              (err),
        .first_fail_valid (first_fail_valid),
        .first_fail_inst  (first_fail_inst)
    );

    int total  = 0;
    int passed = 0;

    // ---------------- driver tasks ----------------
    // Inputs change and outputs are sampled 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [31:0] word, input logic done);
        pcEn   = en;
        inst   = word;
        OpDone = done;
        step();
        pcEn   = 1'b0;
        OpDone = 1'b0;
    endtask

    task automatic do_reset();
        pcEn = 1'b0; OpDone = 1'b0; inst = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (issue_cnt !== 16'd0 || skip_cnt !== 16'd0 || pass_cnt !== 16'd0 ||
                     fail_cnt !== 16'd0 || ovf_cnt !== 16'd0 || spurious_cnt !== 16'd0)
            $display("FAIL reset_counters got %0d %0d %0d %0d %0d %0d want all 0",
                     issue_cnt, skip_cnt, pass_cnt, fail_cnt, ovf_cnt, spurious_cnt);
        else passed++;
        total++; if (pending !== 3'd0 || idle !== 1'b1 || err !== 1'b0 ||
                     first_fail_valid !== 1'b0 || first_fail_inst !== 32'd0)
            $display("FAIL reset_status got pend=%0d idle=%0b err=%0b ffv=%0b ffi=%h want 0 1 0 0 0",
                     pending, idle, err, first_fail_valid, first_fail_inst);
        else passed++;
    endtask

    task automatic test_pass();
        do_reset();
        drive(1'b1, {ADD_op, 26'h0123456}, 1'b0);
        total++; if (pending !== 3'd1 || idle !== 1'b0)
            $display("FAIL pass_pending_after_issue got %0d idle=%0b want 1 idle=0", pending, idle);
        else passed++;
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1);
        total++; if (pass_cnt !== 16'd1 || issue_cnt !== 16'd1)
            $display("FAIL pass_counts got pass=%0d issue=%0d want 1 1", pass_cnt, issue_cnt);
        else passed++;
        total++; if (pending !== 3'd0 || idle !== 1'b1 || err !== 1'b0 || fail_cnt !== 16'd0)
            $display("FAIL pass_status got pend=%0d idle=%0b err=%0b fail=%0d want 0 1 0 0",
                     pending, idle, err, fail_cnt);
        else passed++;
    endtask

    task automatic test_timeout();
        logic [31:0] w1, w2;
        w1 = {ADDI_op, 26'h2ABCDEF};
        w2 = {ADDI_op, 26'h1555555};
        do_reset();
        drive(1'b1, w1, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) drive(1'b0, '0, 1'b0);
        total++; if (fail_cnt !== 16'd0 || err !== 1'b0)
            $display("FAIL timeout_early got fail=%0d err=%0b want 0 0", fail_cnt, err);
        else passed++;
        drive(1'b0, '0, 1'b0);
        total++; if (fail_cnt !== 16'd1 || err !== 1'b1 || pending !== 3'd0)
            $display("FAIL timeout_exact got fail=%0d err=%0b pend=%0d want 1 1 0", fail_cnt, err, pending);
        else passed++;
        total++; if (first_fail_valid !== 1'b1 || first_fail_inst !== w1)
            $display("FAIL timeout_first_inst got v=%0b %h want 1 %h", first_fail_valid, first_fail_inst, w1);
        else passed++;
        drive(1'b1, w2, 1'b0);
        for (int i = 0; i < TIMEOUT; i++) drive(1'b0, '0, 1'b0);
        total++; if (fail_cnt !== 16'd2 || first_fail_inst !== w1 || first_fail_valid !== 1'b1)
            $display("FAIL timeout_second got fail=%0d ffi=%h want 2 %h", fail_cnt, first_fail_inst, w1);
        else passed++;
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, {ADD_op, 26'(i)}, 1'b0);
        total++; if (issue_cnt !== 16'd4 || pending !== 3'd4 || ovf_cnt !== 16'd0 || err !== 1'b0)
            $display("FAIL ovf_fill got issue=%0d pend=%0d ovf=%0d err=%0b want 4 4 0 0",
                     issue_cnt, pending, ovf_cnt, err);
        else passed++;
        drive(1'b1, {ADD_op, 26'd4}, 1'b0);
        total++; if (issue_cnt !== 16'd4 || ovf_cnt !== 16'd1 || pending !== 3'd4 || err !== 1'b1)
            $display("FAIL ovf_drop got issue=%0d ovf=%0d pend=%0d err=%0b want 4 1 4 1",
                     issue_cnt, ovf_cnt, pending, err);
        else passed++;
        // Full FIFO: the pop from OpDone makes room for the same-cycle push.
        drive(1'b1, {ADD_op, 26'd5}, 1'b1);
        total++; if (pass_cnt !== 16'd1 || issue_cnt !== 16'd5 || pending !== 3'd4 || ovf_cnt !== 16'd1)
            $display("FAIL ovf_push_pop got pass=%0d issue=%0d pend=%0d ovf=%0d want 1 5 4 1",
                     pass_cnt, issue_cnt, pending, ovf_cnt);
        else passed++;
    endtask

    task automatic test_skip_spurious();
        logic [5:0] ops [5];
        ops = '{LW_op, SW_op, J_op, BEQ_op, BNE_op};
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, {ops[i], 26'h3FFFFFF}, 1'b0);
        total++; if (skip_cnt !== 16'd5 || pending !== 3'd0 || issue_cnt !== 16'd0 || err !== 1'b0)
            $display("FAIL skip got skip=%0d pend=%0d issue=%0d err=%0b want 5 0 0 0",
                     skip_cnt, pending, issue_cnt, err);
        else passed++;
        drive(1'b0, '0, 1'b1);
        total++; if (spurious_cnt !== 16'd1 || err !== 1'b1 || pass_cnt !== 16'd0)
            $display("FAIL spurious got spur=%0d err=%0b pass=%0d want 1 1 0", spurious_cnt, err, pass_cnt);
        else passed++;
        // OpDone alongside a push into an empty FIFO is spurious; entry stays.
        drive(1'b1, {ADD_op, 26'd7}, 1'b1);
        total++; if (spurious_cnt !== 16'd2 || pass_cnt !== 16'd0 || pending !== 3'd1)
            $display("FAIL same_cycle_push got spur=%0d pass=%0d pend=%0d want 2 0 1",
                     spurious_cnt, pass_cnt, pending);
        else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        for (int c = 0; c < 300; c++)
            drive(c % 3 == 0, {ADD_op, 26'(c)}, c % 3 == 2);
        drive(1'b0, '0, 1'b0);
        total++; if (pass_cnt !== 16'd100 || issue_cnt !== 16'd100 || fail_cnt !== 16'd0)
            $display("FAIL wrap_counts got pass=%0d issue=%0d fail=%0d want 100 100 0",
                     pass_cnt, issue_cnt, fail_cnt);
        else passed++;
        total++; if (pending !== 3'd0 || err !== 1'b0 || spurious_cnt !== 16'd0)
            $display("FAIL wrap_status got pend=%0d err=%0b spur=%0d want 0 0 0", pending, err, spurious_cnt);
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, {ADD_op, 26'(i)}, 1'b0);
        drive(1'b0, '0, 1'b1);
        total++; if (pending !== 3'd3 || err !== 1'b1)
            $display("FAIL mid_setup got pend=%0d err=%0b want 3 1", pending, err);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (pending !== 3'd0 || idle !== 1'b1 || err !== 1'b0 || issue_cnt !== 16'd0 ||
                     pass_cnt !== 16'd0 || ovf_cnt !== 16'd0)
            $display("FAIL mid_async got pend=%0d idle=%0b err=%0b issue=%0d pass=%0d ovf=%0d want 0 1 0 0 0 0",
                     pending, idle, err, issue_cnt, pass_cnt, ovf_cnt);
        else passed++;
        step();
        rst_n = 1'b1;
        drive(1'b1, {ADDI_op, 26'd9}, 1'b0);
        drive(1'b0, '0, 1'b0);
        drive(1'b0, '0, 1'b1);
        total++; if (issue_cnt !== 16'd1 || pass_cnt !== 16'd1 || pending !== 3'd0 ||
                     err !== 1'b0 || fail_cnt !== 16'd0)
            $display("FAIL mid_resume got issue=%0d pass=%0d pend=%0d err=%0b fail=%0d want 1 1 0 0 0",
                     issue_cnt, pass_cnt, pending, err, fail_cnt);
        else passed++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        #2;
        test_reset();
        test_pass();
        test_timeout();
        test_overflow();
        test_skip_spurious();
        test_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
